// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: ID/EX/MEM/WB hazard sources and memory status in,
// pipeline enables, flush/bubble controls and performance counters out.
//   slave  : the controller (consumes hazard info, drives controls)
//   master : the pipeline datapath (drives hazard info, consumes controls)
interface pipeline_hazard_controller_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic [4:0]  mem_dest;
  logic        mem_reg_write;
  logic [4:0]  wb_dest;
  logic        wb_reg_write;
  logic        branch_taken_ex;
  logic        mem_busy;
  logic        pc_enable;
  logic        pc_redirect;
  logic        ifid_enable;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        exmem_enable;
  logic        memwb_enable;
  logic        rf_we_gate;
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;
  logic        mem_timeout;

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_dest, ex_reg_write, mem_dest, mem_reg_write,
           wb_dest, wb_reg_write, branch_taken_ex, mem_busy,
    output pc_enable, pc_redirect, ifid_enable, ifid_flush, idex_bubble,
           exmem_enable, memwb_enable, rf_we_gate, stall_cycles, flush_events, mem_timeout
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_dest, ex_reg_write, mem_dest, mem_reg_write,
           wb_dest, wb_reg_write, branch_taken_ex, mem_busy,
    input  pc_enable, pc_redirect, ifid_enable, ifid_flush, idex_bubble,
           exmem_enable, memwb_enable, rf_we_gate, stall_cycles, flush_events, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW interlocks (no forwarding),
// EX-resolved redirects, start-up bubbles and memory wait, plus stall/flush
// counters and a sticky memory-timeout flag.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-low reset
//   bus   - hazard inputs and pipeline control outputs (slave modport)
// Control outputs are combinational from state and inputs.
module pipeline_hazard_controller #(
  parameter int unsigned STARTUP_CYCLES   = 1,
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter bit          WB_BYPASS        = 1'b1,
  parameter int unsigned MEM_TIMEOUT      = 1023
) (
  input logic                         clock,
  input logic                         reset,
  pipeline_hazard_controller_if.slave bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  STARTUP_INIT  = CNT_W'(STARTUP_CYCLES);
  localparam logic [CNT_W-1:0]  REDIRECT_INIT = CNT_W'(REDIRECT_BUBBLES);
  localparam logic [WAIT_W-1:0] WAIT_MAX      = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {ST_START, ST_RUN, ST_FLUSH, ST_MEM_WAIT} state_t;

  state_t            r_state, r_ret_state;
  state_t            w_next_state, w_next_ret_state, w_eff_state;
  logic [CNT_W-1:0]  r_bubble_cnt, w_next_bubble_cnt;
  logic [WAIT_W-1:0] r_wait_cnt, w_next_wait_cnt;
  logic [31:0]       r_stall_cycles;
  logic [15:0]       r_flush_events;
  logic              r_mem_timeout;
  logic              w_rs_hit, w_rt_hit, w_haz, w_bubble_phase;
  logic              w_stall_inc, w_flush_inc;

  function automatic logic stage_hit(input logic we, input logic [4:0] dest,
                                     input logic [4:0] src);
    return we && (dest == src) && (src != 5'd0);
  endfunction

  // RAW detection; with a write-first register file the WB stage cannot conflict
  always_comb begin
    w_rs_hit = stage_hit(bus.ex_reg_write, bus.ex_dest, bus.id_rs)
             | stage_hit(bus.mem_reg_write, bus.mem_dest, bus.id_rs)
             | (!WB_BYPASS && stage_hit(bus.wb_reg_write, bus.wb_dest, bus.id_rs));
    w_rt_hit = stage_hit(bus.ex_reg_write, bus.ex_dest, bus.id_rt)
             | stage_hit(bus.mem_reg_write, bus.mem_dest, bus.id_rt)
             | (!WB_BYPASS && stage_hit(bus.wb_reg_write, bus.wb_dest, bus.id_rt));
    w_haz    = w_rs_hit | (bus.id_uses_rt & w_rt_hit);
  end

  // The cycle that leaves MEM_WAIT behaves as the state that was interrupted
  assign w_eff_state    = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;
  assign w_bubble_phase = ((w_eff_state == ST_START) || (w_eff_state == ST_FLUSH))
                          && (r_bubble_cnt != '0);

  // Saturating count of consecutive busy cycles
  assign w_next_wait_cnt = !bus.mem_busy ? '0 :
                           (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);

  // Next state and prioritized pipeline controls
  always_comb begin
    w_next_state      = r_state;
    w_next_ret_state  = r_ret_state;
    w_next_bubble_cnt = r_bubble_cnt;
    w_stall_inc       = 1'b0;
    w_flush_inc       = 1'b0;
    bus.pc_enable     = 1'b1;
    bus.pc_redirect   = 1'b0;
    bus.ifid_enable   = 1'b1;
    bus.ifid_flush    = 1'b0;
    bus.idex_bubble   = 1'b0;
    bus.exmem_enable  = 1'b1;
    bus.memwb_enable  = 1'b1;
    bus.rf_we_gate    = 1'b1;

    if (!reset) begin
      bus.pc_enable   = 1'b0;
      bus.ifid_enable = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
      bus.rf_we_gate  = 1'b0;
    end else if (bus.mem_busy) begin
      // Freeze everything; WB retires its write only on the first busy cycle
      bus.pc_enable    = 1'b0;
      bus.ifid_enable  = 1'b0;
      bus.exmem_enable = 1'b0;
      bus.memwb_enable = 1'b0;
      bus.rf_we_gate   = (r_state != ST_MEM_WAIT);
      w_next_state     = ST_MEM_WAIT;
      if (r_state != ST_MEM_WAIT) w_next_ret_state = r_state;
    end else if (bus.branch_taken_ex) begin
      // Younger instructions are squashed, so any RAW stall is moot
      bus.pc_redirect   = 1'b1;
      bus.ifid_flush    = 1'b1;
      bus.idex_bubble   = 1'b1;
      w_flush_inc       = 1'b1;
      w_next_bubble_cnt = REDIRECT_INIT;
      w_next_state      = (REDIRECT_INIT == '0) ? ST_RUN : ST_FLUSH;
    end else if (w_bubble_phase) begin
      bus.ifid_flush    = 1'b1;
      bus.idex_bubble   = 1'b1;
      w_next_bubble_cnt = r_bubble_cnt - CNT_W'(1);
      w_next_state      = (r_bubble_cnt == CNT_W'(1)) ? ST_RUN : w_eff_state;
    end else begin
      w_next_state = ST_RUN;
      if (w_haz) begin
        bus.pc_enable   = 1'b0;
        bus.ifid_enable = 1'b0;
        bus.idex_bubble = 1'b1;
        w_stall_inc     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= ST_START;
      r_ret_state    <= ST_START;
      r_bubble_cnt   <= STARTUP_INIT;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
      r_mem_timeout  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_ret_state  <= w_next_ret_state;
      r_bubble_cnt <= w_next_bubble_cnt;
      r_wait_cnt   <= w_next_wait_cnt;
      if (w_stall_inc) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush_inc) r_flush_events <= r_flush_events + 16'd1;
      if (bus.mem_busy && (w_next_wait_cnt == WAIT_MAX)) r_mem_timeout <= 1'b1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_events = r_flush_events;
  assign bus.mem_timeout  = r_mem_timeout;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: dut0 uses WB bypass and the default
// timeout, dut1 has no WB bypass and MEM_TIMEOUT=3; both see the same inputs.
module tb_pipeline_hazard_controller;
  typedef logic [7:0] ctl_t;  // {pc_en, redirect, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en, rf_we}
  localparam ctl_t C_NORM  = 8'b1010_0111;
  localparam ctl_t C_RST   = 8'b0001_1110;
  localparam ctl_t C_BUB   = 8'b1011_1111;
  localparam ctl_t C_STALL = 8'b0000_1111;
  localparam ctl_t C_REDIR = 8'b1111_1111;
  localparam ctl_t C_BUSY1 = 8'b0000_0001;
  localparam ctl_t C_BUSY  = 8'b0000_0000;

  typedef struct packed {
    logic rst_n; logic [4:0] rs; logic [4:0] rt; logic uses_rt;
    logic [4:0] exd; logic exw; logic [4:0] memd; logic memw;
    logic [4:0] wbd; logic wbw; logic br; logic busy;
  } stim_t;

  typedef struct packed {
    ctl_t c0; ctl_t c1; logic [31:0] st; logic [15:0] fl; logic tmo0; logic tmo1;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipeline_hazard_controller_if bus0();
  pipeline_hazard_controller_if bus1();

  assign bus1.id_rs           = bus0.id_rs;
  assign bus1.id_rt           = bus0.id_rt;
  assign bus1.id_uses_rt      = bus0.id_uses_rt;
  assign bus1.ex_dest         = bus0.ex_dest;
  assign bus1.ex_reg_write    = bus0.ex_reg_write;
  assign bus1.mem_dest        = bus0.mem_dest;
  assign bus1.mem_reg_write   = bus0.mem_reg_write;
  assign bus1.wb_dest         = bus0.wb_dest;
  assign bus1.wb_reg_write    = bus0.wb_reg_write;
  assign bus1.branch_taken_ex = bus0.branch_taken_ex;
  assign bus1.mem_busy        = bus0.mem_busy;

  pipeline_hazard_controller #(.STARTUP_CYCLES(1), .REDIRECT_BUBBLES(1), .WB_BYPASS(1'b1),
                               .MEM_TIMEOUT(1023))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));
  pipeline_hazard_controller #(.STARTUP_CYCLES(1), .REDIRECT_BUBBLES(1), .WB_BYPASS(1'b0),
                               .MEM_TIMEOUT(3))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  ctl_t ctl0, ctl1;
  assign ctl0 = {bus0.pc_enable, bus0.pc_redirect, bus0.ifid_enable, bus0.ifid_flush,
                 bus0.idex_bubble, bus0.exmem_enable, bus0.memwb_enable, bus0.rf_we_gate};
  assign ctl1 = {bus1.pc_enable, bus1.pc_redirect, bus1.ifid_enable, bus1.ifid_flush,
                 bus1.idex_bubble, bus1.exmem_enable, bus1.memwb_enable, bus1.rf_we_gate};

  exp_t        q[$];
  exp_t        x;
  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_st = '0;
  logic [15:0] exp_fl = '0;
  logic        exp_tmo0 = 1'b0;
  logic        exp_tmo1 = 1'b0;
  int          busy_run = 0;

  function automatic stim_t mk(input int rs, input int rt, input int uses_rt, input int exd,
                               input int exw, input int memd, input int memw, input int wbd,
                               input int wbw, input int br, input int busy);
    stim_t s;
    s.rst_n = 1'b1;       s.rs = 5'(rs);     s.rt = 5'(rt);       s.uses_rt = 1'(uses_rt);
    s.exd = 5'(exd);      s.exw = 1'(exw);   s.memd = 5'(memd);   s.memw = 1'(memw);
    s.wbd = 5'(wbd);      s.wbw = 1'(wbw);   s.br = 1'(br);       s.busy = 1'(busy);
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t rst_stim();
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    return s;
  endfunction

  // Apply one cycle of stimulus, queue its expectation, move to the sample point
  task automatic drive_push(input stim_t s, input ctl_t e0, input ctl_t e1);
    exp_t e;
    reset                = s.rst_n;
    bus0.id_rs           = s.rs;
    bus0.id_rt           = s.rt;
    bus0.id_uses_rt      = s.uses_rt;
    bus0.ex_dest         = s.exd;
    bus0.ex_reg_write    = s.exw;
    bus0.mem_dest        = s.memd;
    bus0.mem_reg_write   = s.memw;
    bus0.wb_dest         = s.wbd;
    bus0.wb_reg_write    = s.wbw;
    bus0.branch_taken_ex = s.br;
    bus0.mem_busy        = s.busy;
    e.c0 = e0; e.c1 = e1; e.st = exp_st; e.fl = exp_fl; e.tmo0 = exp_tmo0; e.tmo1 = exp_tmo1;
    q.push_back(e);
    @(negedge clock);
  endtask

  // Counter/flag model update for the clock edge ending this cycle, then step past it
  task automatic advance(input stim_t s, input ctl_t e0);
    if (!s.rst_n) begin
      exp_st = '0; exp_fl = '0; exp_tmo0 = 1'b0; exp_tmo1 = 1'b0; busy_run = 0;
    end else begin
      if (e0 == C_STALL) exp_st = exp_st + 32'd1;
      if (e0 == C_REDIR) exp_fl = exp_fl + 16'd1;
      if (s.busy) begin
        busy_run = busy_run + 1;
        if (busy_run >= 3)    exp_tmo1 = 1'b1;
        if (busy_run >= 1023) exp_tmo0 = 1'b1;
      end else begin
        busy_run = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    stim_t sv[$]; ctl_t a[$]; ctl_t b[$];
    for (int k = 0; k < 3; k++) begin sv.push_back(rst_stim()); a.push_back(C_RST); b.push_back(C_RST); end
    sv.push_back(idle()); a.push_back(C_BUB);  b.push_back(C_BUB);
    sv.push_back(idle()); a.push_back(C_NORM); b.push_back(C_NORM);
    for (int i = 0; i < sv.size(); i++) begin
      drive_push(sv[i], a[i], b[i]);
      x = q.pop_front();
      total++; if (ctl0 !== x.c0) $display("FAIL reset cyc%0d dut0 ctl got %b want %b", i, ctl0, x.c0); else passed++;
      total++; if (ctl1 !== x.c1) $display("FAIL reset cyc%0d dut1 ctl got %b want %b", i, ctl1, x.c1); else passed++;
      total++; if (bus0.stall_cycles !== x.st) $display("FAIL reset cyc%0d stall_cycles got %0d want %0d", i, bus0.stall_cycles, x.st); else passed++;
      total++; if (bus0.flush_events !== x.fl) $display("FAIL reset cyc%0d flush_events got %0d want %0d", i, bus0.flush_events, x.fl); else passed++;
      total++; if ({bus0.mem_timeout, bus1.mem_timeout} !== {x.tmo0, x.tmo1}) $display("FAIL reset cyc%0d timeout got %b want %b", i, {bus0.mem_timeout, bus1.mem_timeout}, {x.tmo0, x.tmo1}); else passed++;
      advance(sv[i], a[i]);
    end
  endtask

  task automatic test_raw_stall();
    stim_t sv[$]; ctl_t a[$];
    sv.push_back(mk(5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0)); a.push_back(C_STALL);  // EX hit on rs
    sv.push_back(mk(5, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0)); a.push_back(C_STALL);  // MEM hit on rs
    sv.push_back(mk(5, 0, 0, 5, 0, 5, 0, 0, 0, 0, 0)); a.push_back(C_NORM);   // dest match, no write
    sv.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0)); a.push_back(C_NORM);   // $zero never hazards
    sv.push_back(mk(0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0)); a.push_back(C_NORM);   // rt not used
    sv.push_back(mk(0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0)); a.push_back(C_STALL);  // rt used
    sv.push_back(idle());                              a.push_back(C_NORM);
    for (int i = 0; i < sv.size(); i++) begin
      drive_push(sv[i], a[i], a[i]);
      x = q.pop_front();
      total++; if (ctl0 !== x.c0) $display("FAIL raw_stall cyc%0d dut0 ctl got %b want %b", i, ctl0, x.c0); else passed++;
      total++; if (ctl1 !== x.c1) $display("FAIL raw_stall cyc%0d dut1 ctl got %b want %b", i, ctl1, x.c1); else passed++;
      total++; if (bus0.stall_cycles !== x.st) $display("FAIL raw_stall cyc%0d stall_cycles got %0d want %0d", i, bus0.stall_cycles, x.st); else passed++;
      total++; if (bus0.flush_events !== x.fl) $display("FAIL raw_stall cyc%0d flush_events got %0d want %0d", i, bus0.flush_events, x.fl); else passed++;
      advance(sv[i], a[i]);
    end
  endtask

  task automatic test_branch_over_hazard();
    stim_t sv[$]; ctl_t a[$];
    sv.push_back(mk(5, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0)); a.push_back(C_REDIR);  // branch beats RAW
    sv.push_back(mk(5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0)); a.push_back(C_BUB);    // flush bubble, haz ignored
    sv.push_back(idle());                              a.push_back(C_NORM);
    for (int i = 0; i < sv.size(); i++) begin
      drive_push(sv[i], a[i], a[i]);
      x = q.pop_front();
      total++; if (ctl0 !== x.c0) $display("FAIL branch cyc%0d dut0 ctl got %b want %b", i, ctl0, x.c0); else passed++;
      total++; if (ctl1 !== x.c1) $display("FAIL branch cyc%0d dut1 ctl got %b want %b", i, ctl1, x.c1); else passed++;
      total++; if (bus0.stall_cycles !== x.st) $display("FAIL branch cyc%0d stall_cycles got %0d want %0d", i, bus0.stall_cycles, x.st); else passed++;
      total++; if (bus0.flush_events !== x.fl) $display("FAIL branch cyc%0d flush_events got %0d want %0d", i, bus0.flush_events, x.fl); else passed++;
      advance(sv[i], a[i]);
    end
  endtask

  task automatic test_mem_busy_flush();
    stim_t sv[$]; ctl_t a[$];
    sv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); a.push_back(C_REDIR);
    sv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); a.push_back(C_BUSY1);
    sv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); a.push_back(C_BUSY);   // busy outranks branch
    sv.push_back(mk(5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1)); a.push_back(C_BUSY);   // busy outranks RAW
    sv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); a.push_back(C_BUSY);
    sv.push_back(idle());                              a.push_back(C_BUB);    // pending flush bubble
    sv.push_back(idle());                              a.push_back(C_NORM);
    for (int i = 0; i < sv.size(); i++) begin
      drive_push(sv[i], a[i], a[i]);
      x = q.pop_front();
      total++; if (ctl0 !== x.c0) $display("FAIL mem_busy cyc%0d dut0 ctl got %b want %b", i, ctl0, x.c0); else passed++;
      total++; if (ctl1 !== x.c1) $display("FAIL mem_busy cyc%0d dut1 ctl got %b want %b", i, ctl1, x.c1); else passed++;
      total++; if (bus0.stall_cycles !== x.st) $display("FAIL mem_busy cyc%0d stall_cycles got %0d want %0d", i, bus0.stall_cycles, x.st); else passed++;
      total++; if (bus0.flush_events !== x.fl) $display("FAIL mem_busy cyc%0d flush_events got %0d want %0d", i, bus0.flush_events, x.fl); else passed++;
      total++; if ({bus0.mem_timeout, bus1.mem_timeout} !== {x.tmo0, x.tmo1}) $display("FAIL mem_busy cyc%0d timeout got %b want %b", i, {bus0.mem_timeout, bus1.mem_timeout}, {x.tmo0, x.tmo1}); else passed++;
      advance(sv[i], a[i]);
    end
  endtask

  task automatic test_wb_bypass();
    stim_t sv[$]; ctl_t a[$]; ctl_t b[$];
    sv.push_back(mk(0, 7, 1, 0, 0, 0, 0, 7, 1, 0, 0)); a.push_back(C_NORM); b.push_back(C_STALL);
    sv.push_back(mk(7, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0)); a.push_back(C_NORM); b.push_back(C_STALL);
    sv.push_back(mk(7, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0)); a.push_back(C_NORM); b.push_back(C_NORM);
    for (int i = 0; i < sv.size(); i++) begin
      drive_push(sv[i], a[i], b[i]);
      x = q.pop_front();
      total++; if (ctl0 !== x.c0) $display("FAIL wb_bypass cyc%0d dut0 ctl got %b want %b", i, ctl0, x.c0); else passed++;
      total++; if (ctl1 !== x.c1) $display("FAIL wb_bypass cyc%0d dut1 ctl got %b want %b", i, ctl1, x.c1); else passed++;
      total++; if (bus0.stall_cycles !== x.st) $display("FAIL wb_bypass cyc%0d stall_cycles got %0d want %0d", i, bus0.stall_cycles, x.st); else passed++;
      advance(sv[i], a[i]);
    end
  endtask

  task automatic test_timeout();
    stim_t sv[$]; ctl_t a[$];
    sv.push_back(rst_stim()); a.push_back(C_RST);
    sv.push_back(idle());     a.push_back(C_BUB);
    sv.push_back(idle());     a.push_back(C_NORM);
    sv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); a.push_back(C_BUSY1);
    for (int k = 0; k < 4; k++) begin sv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); a.push_back(C_BUSY); end
    sv.push_back(idle());     a.push_back(C_NORM);
    sv.push_back(idle());     a.push_back(C_NORM);
    sv.push_back(rst_stim()); a.push_back(C_RST);
    sv.push_back(idle());     a.push_back(C_BUB);
    sv.push_back(idle());     a.push_back(C_NORM);
    for (int i = 0; i < sv.size(); i++) begin
      drive_push(sv[i], a[i], a[i]);
      x = q.pop_front();
      total++; if (ctl0 !== x.c0) $display("FAIL timeout cyc%0d dut0 ctl got %b want %b", i, ctl0, x.c0); else passed++;
      total++; if (ctl1 !== x.c1) $display("FAIL timeout cyc%0d dut1 ctl got %b want %b", i, ctl1, x.c1); else passed++;
      total++; if (bus0.flush_events !== x.fl) $display("FAIL timeout cyc%0d flush_events got %0d want %0d", i, bus0.flush_events, x.fl); else passed++;
      total++; if ({bus0.mem_timeout, bus1.mem_timeout} !== {x.tmo0, x.tmo1}) $display("FAIL timeout cyc%0d timeout got %b want %b", i, {bus0.mem_timeout, bus1.mem_timeout}, {x.tmo0, x.tmo1}); else passed++;
      advance(sv[i], a[i]);
    end
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_branch_over_hazard();
    test_mem_busy_flush();
    test_wb_bypass();
    test_timeout();
    if (q.size() != 0) begin
      total++;
      $display("FAIL scoreboard leftover got %0d entries want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
